sync_fifo_ctrl: RTL and testbench

Single-clock, parametrised FIFO that combines storage and pointer/flag control in one block. It adds the following on top of a bare memory array:
- registered read data with a valid strobe
- occupancy count
- programmable almost-full and almost-empty thresholds
- sticky overflow and underflow error flags
It is used for intra-domain buffering between producer and consumer stages where no clock crossing is needed.

---
 rtl/sync_fifo_ctrl_if.sv | 27 ++
 rtl/sync_fifo_ctrl.sv | 63 ++++++
 tb/tb_sync_fifo_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/sync_fifo_ctrl_if.sv
// sync_fifo_ctrl_if: producer/consumer handshake and status bundle for the FIFO
interface sync_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PTR_WIDTH  = 3
);
  logic                  w_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  r_en;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [PTR_WIDTH:0]    count;
  logic                  overflow;
  logic                  underflow;
  modport master (
    output w_en, data_in, r_en, clr_err,
    input  data_out, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
  modport slave (
    input  w_en, data_in, r_en, clr_err,
    output data_out, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO with registered read data, thresholds and sticky error flags
module sync_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int PTR_WIDTH  = 3,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input logic              clk,
  input logic              rst,
  sync_fifo_ctrl_if.slave  bus
);
  localparam logic [PTR_WIDTH:0] AF = AF_LEVEL[PTR_WIDTH:0];
  localparam logic [PTR_WIDTH:0] AE = AE_LEVEL[PTR_WIDTH:0];
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH:0]    wptr_q, wptr_d, rptr_q, rptr_d, cnt;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  vld_q, vld_d, ovf_q, ovf_d, unf_q, unf_d;
  logic                  full, empty, do_wr, do_rd;
  always_comb begin
    cnt    = wptr_q - rptr_q;
    empty  = wptr_q == rptr_q;
    full   = (wptr_q[PTR_WIDTH-1:0] == rptr_q[PTR_WIDTH-1:0]) && (wptr_q[PTR_WIDTH] != rptr_q[PTR_WIDTH]);
    do_wr  = bus.w_en && !full;
    do_rd  = bus.r_en && !empty;
    wptr_d = do_wr ? wptr_q + 1'b1 : wptr_q;
    rptr_d = do_rd ? rptr_q + 1'b1 : rptr_q;
    dout_d = do_rd ? mem[rptr_q[PTR_WIDTH-1:0]] : dout_q;
    vld_d  = do_rd;
    // a new error in the same cycle as clr_err keeps the flag set
    ovf_d  = (bus.w_en && full) || (ovf_q && !bus.clr_err);
    unf_d  = (bus.r_en && empty) || (unf_q && !bus.clr_err);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      dout_q <= '0;
      vld_q  <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      dout_q <= dout_d;
      vld_q  <= vld_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr_q[PTR_WIDTH-1:0]] <= bus.data_in;
  end
  assign bus.data_out     = dout_q;
  assign bus.rd_valid     = vld_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = cnt >= AF;
  assign bus.almost_empty = cnt <= AE;
  assign bus.count        = cnt;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl: directed checks of fill/drain, errors, wrap, thresholds and async reset
module tb_sync_fifo_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [7:0] q[$];
  logic [7:0] exp_d;
  sync_fifo_ctrl_if #(.DATA_WIDTH(8), .PTR_WIDTH(3)) bus ();
  sync_fifo_ctrl #(.DATA_WIDTH(8), .DEPTH(8), .PTR_WIDTH(3), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
    bus.w_en = w; bus.data_in = d; bus.r_en = r; bus.clr_err = c;
    @(negedge clk);
    bus.w_en = 1'b0; bus.r_en = 1'b0; bus.clr_err = 1'b0;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_count"}, 32'(bus.count), 0);
    chk({tag, "_empty"}, 32'(bus.empty), 1);
    chk({tag, "_full"}, 32'(bus.full), 0);
    chk({tag, "_ae"}, 32'(bus.almost_empty), 1);
    chk({tag, "_af"}, 32'(bus.almost_full), 0);
    chk({tag, "_dout"}, 32'(bus.data_out), 0);
    chk({tag, "_vld"}, 32'(bus.rd_valid), 0);
    chk({tag, "_ovf"}, 32'(bus.overflow), 0);
    chk({tag, "_unf"}, 32'(bus.underflow), 0);
  endtask
  initial begin
    bus.w_en = 1'b0; bus.data_in = 8'h00; bus.r_en = 1'b0; bus.clr_err = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset("rst");
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 8'(8'h11 * i), 1'b0, 1'b0);
      chk("fill_count", 32'(bus.count), 32'(i));
      chk("fill_af", 32'(bus.almost_full), 32'(i >= 6));
      chk("fill_ae", 32'(bus.almost_empty), 32'(i <= 2));
      chk("fill_full", 32'(bus.full), 32'(i == 8));
    end
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("ovf_set", 32'(bus.overflow), 1);
    chk("ovf_count", 32'(bus.count), 8);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr", 32'(bus.overflow), 0);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain_data", 32'(bus.data_out), 32'(8'(8'h11 * i)));
      chk("drain_vld", 32'(bus.rd_valid), 1);
      chk("drain_count", 32'(bus.count), 32'(8 - i));
    end
    chk("drain_empty", 32'(bus.empty), 1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("idle_vld", 32'(bus.rd_valid), 0);
    chk("idle_hold", 32'(bus.data_out), 32'h88);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("unf_set", 32'(bus.underflow), 1);
    chk("unf_vld", 32'(bus.rd_valid), 0);
    chk("unf_dout", 32'(bus.data_out), 32'h88);
    step(1'b1, 8'h5A, 1'b1, 1'b0);
    chk("wr_empty_count", 32'(bus.count), 1);
    chk("wr_empty_unf", 32'(bus.underflow), 1);
    chk("wr_empty_vld", 32'(bus.rd_valid), 0);
    chk("wr_empty_dout", 32'(bus.data_out), 32'h88);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("rd_5a", 32'(bus.data_out), 32'h5A);
    chk("rd_5a_vld", 32'(bus.rd_valid), 1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("clr_vs_set", 32'(bus.underflow), 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("unf_clr", 32'(bus.underflow), 0);
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      q.push_back(8'(i));
    end
    chk("ae_at3", 32'(bus.almost_empty), 0);
    chk("pre_wrap_count", 32'(bus.count), 3);
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 8'(8'h20 + k), 1'b1, 1'b0);
      q.push_back(8'(8'h20 + k));
      exp_d = q.pop_front();
      chk("wrap_data", 32'(bus.data_out), 32'(exp_d));
      chk("wrap_count", 32'(bus.count), 3);
    end
    for (int i = 4; i <= 6; i++) begin
      step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
      q.push_back(8'(8'h40 + i));
      chk("af_rise", 32'(bus.almost_full), 32'(i == 6));
    end
    step(1'b1, 8'h99, 1'b1, 1'b0);
    q.push_back(8'h99);
    exp_d = q.pop_front();
    chk("af_pair_hold", 32'(bus.almost_full), 1);
    chk("af_pair_data", 32'(bus.data_out), 32'(exp_d));
    step(1'b0, 8'h00, 1'b1, 1'b0);
    exp_d = q.pop_front();
    chk("pre_rst_data", 32'(bus.data_out), 32'(exp_d));
    chk("pre_rst_count", 32'(bus.count), 5);
    bus.w_en = 1'b1; bus.data_in = 8'hEE;
    #3 rst = 1'b1;
    #1 chk_reset("async");
    @(negedge clk);
    bus.w_en = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    step(1'b1, 8'h77, 1'b0, 1'b0);
    chk("post_rst_count", 32'(bus.count), 1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_data", 32'(bus.data_out), 32'h77);
    chk("post_rst_vld", 32'(bus.rd_valid), 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
